// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage of the 21-bit SIMD AES pipeline. Drives read addresses to a
// synchronous instruction memory (data returns one edge later), keeps track of
// which address the returning word belongs to, and presents PC / instruction /
// valid to the IF/ID pipeline register. It handles stall, branch redirect and
// HALT opcode detection.
//
// Ports
//   clk            in   pipeline clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   1 = hold (shared with IF/ID writeEn)
//   branchTaken    in   redirect request from ID/EX
//   branchTarget   in   redirect address
//   imemAddr       out  instruction memory read address (combinational)
//   imemData       in   memory word for the address sampled at the last edge
//   IF_PC          out  address of IF_Instruction
//   IF_Instruction out  fetched word, NOP when not valid
//   IF_Valid       out  output word is on the correct path
//   halted         out  FSM is in HALT
//   fetchCount     out  saturating count of words accepted by IF/ID
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter int                 PC_WIDTH    = 12,
   parameter int                 INSTR_WIDTH = 21,
   parameter int                 RESET_PC    = 0,
   parameter logic [4:0]         HALT_OPCODE = 5'b11111,
   parameter logic [INSTR_WIDTH-1:0] NOP     = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   branchTaken,
   input  logic [PC_WIDTH-1:0]    branchTarget,
   output logic [PC_WIDTH-1:0]    imemAddr,
   input  logic [INSTR_WIDTH-1:0] imemData,
   output logic [PC_WIDTH-1:0]    IF_PC,
   output logic [INSTR_WIDTH-1:0] IF_Instruction,
   output logic                   IF_Valid,
   output logic                   halted,
   output logic [15:0]            fetchCount
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   r_pc_req;
   logic                  r_req_valid;
   logic [15:0]           r_fetch_count;

   logic                  w_branch;
   logic                  w_valid;
   logic                  w_accept;
   logic                  w_halt_hit;

   // A redirect is ignored in BOOT; the first fetch always comes from RESET_PC.
   assign w_branch   = branchTaken & (r_state != BOOT);
   assign w_valid    = r_req_valid & ~branchTaken & (r_state == RUN);
   assign w_accept   = w_valid & ~stall;
   // HALT only fires once the HALT word is actually handed to IF/ID.
   assign w_halt_hit = w_accept & (imemData[INSTR_WIDTH-1:INSTR_WIDTH-5] == HALT_OPCODE);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BOOT:    w_state_nxt = RUN;
         RUN: begin
            if (branchTaken)     w_state_nxt = RUN;
            else if (w_halt_hit) w_state_nxt = HALT;
         end
         HALT: begin
            if (branchTaken)     w_state_nxt = RUN;
         end
         default: w_state_nxt = BOOT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      imemAddr       = r_pc;
      IF_PC          = r_pc_req;
      IF_Valid       = w_valid;
      IF_Instruction = w_valid ? imemData : NOP;
      halted         = (r_state == HALT);
      fetchCount     = r_fetch_count;
      if (w_branch) begin
         imemAddr = branchTarget;
      end else if ((r_state == RUN) && stall) begin
         // Re-read the word currently on display so it is still there after the stall.
         imemAddr = r_pc_req;
      end
   end

   // ---------------- fetch address tracking ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RST_PC;
         r_pc_req    <= RST_PC;
         r_req_valid <= 1'b0;
      end else if (r_state == BOOT) begin
         r_pc_req    <= RST_PC;
         r_pc        <= RST_PC + 1'b1;
         r_req_valid <= 1'b1;
      end else if (w_branch) begin
         r_pc_req    <= branchTarget;
         r_pc        <= branchTarget + 1'b1;
         r_req_valid <= 1'b1;
      end else if ((r_state == RUN) && !stall) begin
         if (w_halt_hit) begin
            // Freeze on the HALT address; only a redirect or reset restarts fetch.
            r_req_valid <= 1'b0;
         end else begin
            r_pc_req    <= r_pc;
            r_pc        <= r_pc + 1'b1;
            r_req_valid <= 1'b1;
         end
      end
   end

   // ---------------- accepted-instruction counter ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_count <= 16'd0;
      end else if (w_accept && (r_fetch_count != 16'hFFFF)) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   localparam logic [20:0] HALT_WORD = {5'b11111, 16'd110};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branchTaken;
   logic [11:0] branchTarget;
   logic [11:0] imemAddr;
   logic [20:0] imemData;
   logic [11:0] IF_PC;
   logic [20:0] IF_Instruction;
   logic        IF_Valid;
   logic        halted;
   logic [15:0] fetchCount;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_fc   = 0;

   typedef struct {
      logic        v;
      logic [11:0] pc;
      logic [20:0] ins;
   } exp_t;
   exp_t sb[$];

   logic [20:0] mem [0:4095];

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .branchTaken    (branchTaken),
      .branchTarget   (branchTarget),
      .imemAddr       (imemAddr),
      .imemData       (imemData),
      .IF_PC          (IF_PC),
      .IF_Instruction (IF_Instruction),
      .IF_Valid       (IF_Valid),
      .halted         (halted),
      .fetchCount     (fetchCount)
   );

   always #5 clk = ~clk;

   // synchronous instruction memory
   always @(posedge clk) imemData <= mem[imemAddr];

   function automatic logic [20:0] word_at(input logic [11:0] a);
      return (a == 12'd10) ? HALT_WORD : 21'(a) + 21'd100;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".IF_PC"},   32'(IF_PC), 32'd0);
      check({tag, ".instr"},   32'(IF_Instruction), 32'd0);
      check({tag, ".valid"},   32'(IF_Valid), 32'd0);
      check({tag, ".halted"},  32'(halted), 32'd0);
      check({tag, ".fcount"},  32'(fetchCount), 32'd0);
      check({tag, ".imemAddr"},32'(imemAddr), 32'd0);
   endtask

   // Drive one cycle: inputs applied just after posedge, expected output pushed,
   // compared at negedge, then advance to just after the next posedge.
   task automatic step(input logic st, input logic br, input logic [11:0] tgt,
                       input logic ev, input logic [11:0] epc);
      exp_t e;
      exp_t o;
      stall        = st;
      branchTaken  = br;
      branchTarget = tgt;
      e.v   = ev;
      e.pc  = epc;
      e.ins = ev ? word_at(epc) : 21'd0;
      sb.push_back(e);
      @(negedge clk);
      o = sb.pop_front();
      check("valid", 32'(IF_Valid), 32'(o.v));
      check("instr", 32'(IF_Instruction), 32'(o.ins));
      if (o.v) check("pc", 32'(IF_PC), 32'(o.pc));
      if (br)  check("br_addr", 32'(imemAddr), 32'(tgt));
      check("fcount", 32'(fetchCount), 32'(exp_fc));
      @(posedge clk);
      #1;
      if (o.v && !st) exp_fc++;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = word_at(12'(i));
      rst_n = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
      #2;
      check_reset_vals("reset");
      #5;                      // t=7, one edge seen in reset
      rst_n = 1'b1;

      // boot latency, then sequential fetch
      step(0, 0, 0, 0, 0);
      for (int p = 0; p < 5; p++) step(0, 0, 0, 1, 12'(p));
      // stall 3 cycles on PC 5, then release
      for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 12'd5);
      step(0, 0, 0, 1, 12'd5);
      step(0, 0, 0, 1, 12'd6);
      step(0, 0, 0, 1, 12'd7);
      check("fcount_after_stall", 32'(fetchCount), 32'd8);

      // branch while PC 8 on output
      step(0, 1, 12'd40, 0, 0);
      step(0, 0, 0, 1, 12'd40);
      step(0, 0, 0, 1, 12'd41);
      // branch with concurrent stall
      step(1, 1, 12'd40, 0, 0);
      step(0, 0, 0, 1, 12'd40);
      step(0, 0, 0, 1, 12'd41);

      // HALT word squashed by a simultaneous branch
      step(0, 1, 12'd9, 0, 0);
      step(0, 0, 0, 1, 12'd9);
      step(0, 1, 12'd20, 0, 0);      // HALT word at 10 would be on output here
      check("no_halt_on_squash", 32'(halted), 32'd0);
      step(0, 0, 0, 1, 12'd20);

      // real HALT at address 10
      step(0, 1, 12'd8, 0, 0);
      step(0, 0, 0, 1, 12'd8);
      step(0, 0, 0, 1, 12'd9);
      step(0, 0, 0, 1, 12'd10);
      check("halted", 32'(halted), 32'd1);
      for (int k = 0; k < 4; k++) step(k[0], 0, 0, 0, 0);
      check("halted_held", 32'(halted), 32'd1);
      step(0, 1, 12'd0, 0, 0);
      check("halt_exit", 32'(halted), 32'd0);
      step(0, 0, 0, 1, 12'd0);
      step(0, 0, 0, 1, 12'd1);

      // wrap at top of address space
      step(0, 1, 12'd4094, 0, 0);
      step(0, 0, 0, 1, 12'd4094);
      step(0, 0, 0, 1, 12'd4095);
      step(0, 0, 0, 1, 12'd0);
      step(0, 0, 0, 1, 12'd1);

      // asynchronous reset pulse mid-stream
      stall = 1'b0; branchTaken = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      exp_fc = 0;
      #2;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 12'd0);
      step(0, 0, 0, 1, 12'd1);
      step(0, 0, 0, 1, 12'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
